xc_malu_pmul_seq: RTL and testbench
===================================

Name: xc_malu_pmul_seq

Overview:
- Standalone multi-cycle packed multiplier for the XCrypto MALU. Generalised successor to the combinational-step packed multiply datapath.
- Owns its own iteration counter, accumulator and handshake, so the MALU sequencer only issues and collects.
- Parametrised in operand width and bits retired per cycle.
- Supports packed lane widths 32/16/8/4/2, signed/unsigned operands and carry-less (GF(2)) mode.
- Produces a full double-width product split into hi/lo words.

Parameters:
- XLEN, 32, operand width; must be a multiple of 32.
- STEP, 1, multiplier bits consumed per cycle; legal values 1, 2, 4.

Ports:
- g_clk  in  1  clock, rising edge.
- g_resetn  in  1  asynchronous active-low reset.
- valid  in  1  request; operands sampled when valid && !busy.
- flush  in  1  abort any operation, return to IDLE.
- rs1  in  XLEN  multiplicand (lhs).
- rs2  in  XLEN  multiplier (rhs).
- pw_32, pw_16, pw_8, pw_4, pw_2  in  1 each  packed lane width select.
- carryless  in  1  XOR accumulation instead of add.
- lhs_sign  in  1  treat lhs lanes as two's complement.
- rhs_sign  in  1  treat rhs lanes as two's complement.
- busy  out  1  operation in flight (RUN state).
- ready  out  1  one-cycle result-valid pulse.
- result_hi  out  XLEN  high halves of each lane product.
- result_lo  out  XLEN  low halves of each lane product.

Behaviour:
- Reset: state=IDLE, counter=0, busy=0, ready=0, result_hi=0, result_lo=0. Reset is asynchronous and active-low on g_resetn; it overrides any operation mid-flight.
- States: IDLE, RUN, DONE.
  - IDLE/DONE → RUN on valid && !flush. Operands and mode are latched and the counter is cleared.
  - RUN → DONE when counter == XLEN/STEP-1 on that edge.
  - DONE → IDLE after one cycle unless a new valid is accepted.
- Latency: ready is high exactly XLEN/STEP+1 cycles after the accepting edge (33 cycles for 32/1), for one cycle.
- result_hi/result_lo update only on entry to DONE and hold until the next DONE or reset.
- busy=1 only in RUN. valid during RUN is ignored and not queued.
- flush:
  - In RUN → IDLE next edge, no ready pulse, results unchanged.
  - flush has priority over a same-cycle valid.
  - flush in IDLE/DONE is a no-op, apart from blocking accept.
- Lane width select:
  - Priority pw_32 > pw_16 > pw_8 > pw_4 > pw_2; none asserted is treated as pw_32.
  - Lane width w = 32 >> k. XLEN > 32 replicates 32-bit groups.
- Per lane i (bits [i*w +: w]):
  - product P_i has 2w bits.
  - result_lo[i*w +: w] = P_i[w-1:0]; result_hi[i*w +: w] = P_i[2w-1:w].
  - No carry or partial product crosses a lane boundary.
- Arithmetic mode (carryless=0):
  - Lane MSB is the sign bit when the corresponding *_sign is set.
  - P_i is the exact 2w-bit two's-complement product of the signed/unsigned interpretations, wrapped modulo 2^(2w).
  - lhs_sign != rhs_sign (mixed, mulhsu-style) is legal.
- Carry-less mode (carryless=1): P_i = polynomial product over GF(2); sign inputs ignored.
- Operand inputs may change freely after the accepting edge.

Optional Feature:
- Macro XC_MALU_PMUL_EARLY_EXIT_EN.
- Defined:
  - In RUN, if the unconsumed multiplier bits of all lanes are zero and rhs_sign=0 or carryless=1, go to DONE on the next edge.
  - Minimum latency is 2 cycles (rs2=0). Results are identical to the full-latency run.
- Undefined: latency is always XLEN/STEP+1; no zero-detect logic is present.

Test Plan:
- XLEN=32, STEP=1, pw_32, unsigned, rs1=rs2=0xFFFFFFFF → ready 33 cycles after accept; hi=0xFFFFFFFE, lo=0x00000001; busy high for 32 cycles.
- pw_32, lhs_sign=rhs_sign=1, rs1=rs2=0xFFFFFFFF (-1*-1) → hi=0x00000000, lo=0x00000001. Same operands with lhs_sign=1, rhs_sign=0 → hi=0xFFFFFFFF, lo=0x00000001.
- pw_8 unsigned, rs1=0x02030405, rs2=0x10101010 → lo=0x20304050, hi=0x00000000. Repeat with rs1=0xFF000000, rs2=0x02000000 → lo=0xFE000000, hi=0x01000000; lower lanes are 0, no cross-lane carry.
- pw_32, carryless=1, rs1=0x3, rs2=0x3 → lo=0x5, hi=0x0. rs1=rs2=0x80000000 → hi=0x40000000, lo=0.
- Accept, then flush at cycle 10 of RUN → no ready pulse, busy drops next cycle, previous results retained.
  - valid asserted during RUN is ignored.
  - Back-to-back valid held across DONE → second operation accepted in the DONE cycle; ready pulses 33 cycles apart.
- STEP=4 build: random operands in all five widths vs. a reference model → ready after 9 cycles, exact match. With XC_MALU_PMUL_EARLY_EXIT_EN and rs2=0 → ready 2 cycles after accept, hi=lo=0.
- Async reset asserted mid-RUN → all outputs 0 immediately; next valid after release starts a clean operation.

Source files
------------

// File: rtl/xc_malu_pmul_seq.sv
// Multi-cycle packed multiplier for the XCrypto MALU: 32/16/8/4/2-bit lanes, signed/unsigned, carry-less.
// Optional XC_MALU_PMUL_EARLY_EXIT_EN finishes as soon as the remaining multiplier bits are all zero.
module xc_malu_pmul_seq #(
    parameter int XLEN = 32,
    parameter int STEP = 1
) (
    input  logic            g_clk,
    input  logic            g_resetn,
    input  logic            valid,
    input  logic            flush,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            pw_32,
    input  logic            pw_16,
    input  logic            pw_8,
    input  logic            pw_4,
    input  logic            pw_2,
    input  logic            carryless,
    input  logic            lhs_sign,
    input  logic            rhs_sign,
    output logic            busy,
    output logic            ready,
    output logic [XLEN-1:0] result_hi,
    output logic [XLEN-1:0] result_lo
);

    localparam int NCYC = XLEN / STEP;
    localparam int CW   = $clog2(NCYC);
    localparam int AW   = 2 * XLEN;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]      state;
    logic [CW-1:0]   counter;
    logic [XLEN-1:0] lhs_q;
    logic [XLEN-1:0] rhs_q;
    logic [AW-1:0]   acc_q;
    logic [AW-1:0]   acc_nx;
    logic [2:0]      lw_q;
    logic [2:0]      lw_in;
    logic            cl_q;
    logic            ls_q;
    logic            rs_q;
    logic            last_step;

    // Accumulator keeps each lane's 2w-bit product contiguous: lane i lives at [i*2w +: 2w].
    // Bit j of the multiplier word belongs to lane j/w at position j%w, so lanes are retired in order.
    function automatic logic [AW-1:0] mac_bit(
        input logic [AW-1:0]   acc,
        input logic [XLEN-1:0] lhs,
        input logic            mbit,
        input int              j,
        input logic [2:0]      lw,
        input logic            cl,
        input logic            ls,
        input logic            rs
    );
        int          w;
        int          i;
        int          b;
        logic [63:0] mask_w;
        logic [63:0] mask_2w;
        logic [63:0] la;
        logic [63:0] pp;
        logic [63:0] lacc;
        logic [63:0] lnew;
        w       = 1 << lw;
        i       = j >> lw;
        b       = j & (w - 1);
        mask_w  = (64'd1 << w) - 64'd1;
        mask_2w = (w == 32) ? '1 : ((64'd1 << (2 * w)) - 64'd1);
        la      = 64'(lhs >> (i * w)) & mask_w;
        if (ls && !cl && la[w-1])
            la = la | (mask_2w & ~mask_w);
        pp   = mbit ? ((la << b) & mask_2w) : 64'd0;
        lacc = 64'(acc >> (i * 2 * w)) & mask_2w;
        // A signed multiplier's MSB carries weight -2^(w-1), so that partial product is subtracted.
        if (cl)
            lnew = lacc ^ pp;
        else if (rs && (b == w - 1))
            lnew = (lacc - pp) & mask_2w;
        else
            lnew = (lacc + pp) & mask_2w;
        return (acc & ~(AW'(mask_2w) << (i * 2 * w))) | (AW'(lnew) << (i * 2 * w));
    endfunction

    // Packs lane products back into hi/lo words: bit n of lane i maps to acc[2n - b] / acc[2n - b + w].
    function automatic logic [AW-1:0] split_acc(input logic [AW-1:0] acc, input logic [2:0] lw);
        logic [XLEN-1:0] hi;
        logic [XLEN-1:0] lo;
        int              w;
        int              b;
        w = 1 << lw;
        for (int n = 0; n < XLEN; n++) begin
            b     = n & (w - 1);
            lo[n] = acc[2 * n - b];
            hi[n] = acc[2 * n - b + w];
        end
        return {hi, lo};
    endfunction

    always_comb begin
        if (pw_32)      lw_in = 3'd5;
        else if (pw_16) lw_in = 3'd4;
        else if (pw_8)  lw_in = 3'd3;
        else if (pw_4)  lw_in = 3'd2;
        else if (pw_2)  lw_in = 3'd1;
        else            lw_in = 3'd5;
    end

    // NOTE: acc_nx is defaulted before the loop so every path assigns it and no latch is inferred;
    // blocking assignments chain the STEP updates within one cycle.
    always_comb begin
        acc_nx = acc_q;
        for (int s = 0; s < STEP; s++)
            acc_nx = mac_bit(acc_nx, lhs_q, rhs_q[s], int'(counter) * STEP + s,
                             lw_q, cl_q, ls_q, rs_q);
    end

`ifdef XC_MALU_PMUL_EARLY_EXIT_EN
    assign last_step = (counter == CW'(NCYC - 1)) ||
                       (((rhs_q >> STEP) == '0) && (!rs_q || cl_q));
`else
    assign last_step = (counter == CW'(NCYC - 1));
`endif

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state     <= S_IDLE;
            counter   <= '0;
            lhs_q     <= '0;
            rhs_q     <= '0;
            acc_q     <= '0;
            lw_q      <= 3'd5;
            cl_q      <= 1'b0;
            ls_q      <= 1'b0;
            rs_q      <= 1'b0;
            result_hi <= '0;
            result_lo <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (valid && !flush) begin
                        state   <= S_RUN;
                        counter <= '0;
                        acc_q   <= '0;
                        lhs_q   <= rs1;
                        rhs_q   <= rs2;
                        lw_q    <= lw_in;
                        cl_q    <= carryless;
                        ls_q    <= lhs_sign;
                        rs_q    <= rhs_sign;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else begin
                        acc_q   <= acc_nx;
                        rhs_q   <= rhs_q >> STEP;
                        counter <= counter + CW'(1);
                        if (last_step) begin
                            state                  <= S_DONE;
                            {result_hi, result_lo} <= split_acc(acc_nx, lw_q);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy  = (state == S_RUN);
    assign ready = (state == S_DONE);

endmodule

// File: tb/tb_xc_malu_pmul_seq.sv
// Self-checking bench for xc_malu_pmul_seq: vector table plus scoreboard, with flush/back-to-back/reset sequences.
// Expected latency follows XC_MALU_PMUL_EARLY_EXIT_EN when the bench is built with it.
module tb_xc_malu_pmul_seq;

    localparam int XLEN = 32;
    localparam int STEP = 1;
    localparam int NCYC = XLEN / STEP;

    logic            g_clk = 1'b0;
    logic            g_resetn = 1'b0;
    logic            valid = 1'b0;
    logic            flush = 1'b0;
    logic [XLEN-1:0] rs1 = '0;
    logic [XLEN-1:0] rs2 = '0;
    logic            pw_32 = 1'b0;
    logic            pw_16 = 1'b0;
    logic            pw_8 = 1'b0;
    logic            pw_4 = 1'b0;
    logic            pw_2 = 1'b0;
    logic            carryless = 1'b0;
    logic            lhs_sign = 1'b0;
    logic            rhs_sign = 1'b0;
    logic            busy;
    logic            ready;
    logic [XLEN-1:0] result_hi;
    logic [XLEN-1:0] result_lo;

    xc_malu_pmul_seq #(.XLEN(XLEN), .STEP(STEP)) dut (
        .g_clk     (g_clk),
        .g_resetn  (g_resetn),
        .valid     (valid),
        .flush     (flush),
        .rs1       (rs1),
        .rs2       (rs2),
        .pw_32     (pw_32),
        .pw_16     (pw_16),
        .pw_8      (pw_8),
        .pw_4      (pw_4),
        .pw_2      (pw_2),
        .carryless (carryless),
        .lhs_sign  (lhs_sign),
        .rhs_sign  (rhs_sign),
        .busy      (busy),
        .ready     (ready),
        .result_hi (result_hi),
        .result_lo (result_lo)
    );

    always #5 g_clk = ~g_clk;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  pw;    // {pw_32, pw_16, pw_8, pw_4, pw_2}
        logic        cl;
        logic        ls;
        logic        rs;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    vec_t tv[$];
    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: whole-lane multiply with the '*' operator, or a shift/XOR loop for carry-less.
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [4:0] pw, input logic cl,
                                          input logic ls, input logic rs);
        int          w;
        logic [31:0] hi;
        logic [31:0] lo;
        longint      sa;
        longint      sb;
        longint      p;
        if (pw[4])      w = 32;
        else if (pw[3]) w = 16;
        else if (pw[2]) w = 8;
        else if (pw[1]) w = 4;
        else if (pw[0]) w = 2;
        else            w = 32;
        hi = '0;
        lo = '0;
        for (int i = 0; i < 32 / w; i++) begin
            sa = 0;
            sb = 0;
            for (int t = 0; t < w; t++) begin
                sa[t] = a[i * w + t];
                sb[t] = b[i * w + t];
            end
            if (cl) begin
                p = 0;
                for (int t = 0; t < w; t++)
                    if (sb[t]) p = p ^ (sa << t);
            end else begin
                if (ls && sa[w-1]) sa = sa - (longint'(1) << w);
                if (rs && sb[w-1]) sb = sb - (longint'(1) << w);
                p = sa * sb;
            end
            for (int t = 0; t < w; t++) begin
                lo[i * w + t] = p[t];
                hi[i * w + t] = p[w + t];
            end
        end
        return {hi, lo};
    endfunction

    function automatic int exp_lat(input logic [31:0] b, input logic cl, input logic rs);
        int n;
        n = NCYC;
`ifdef XC_MALU_PMUL_EARLY_EXIT_EN
        if (!rs || cl) begin
            int msb;
            msb = -1;
            for (int t = 0; t < XLEN; t++)
                if (b[t]) msb = t;
            n = (msb < 0) ? 1 : (msb / STEP + 1);
        end
`endif
        return n + 1;
    endfunction

    function automatic vec_t mk(input string name, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] pw, input logic cl, input logic ls,
                                input logic rs, input logic [31:0] hi, input logic [31:0] lo);
        vec_t v;
        v.name = name; v.a = a; v.b = b; v.pw = pw;
        v.cl = cl; v.ls = ls; v.rs = rs; v.hi = hi; v.lo = lo;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        {pw_32, pw_16, pw_8, pw_4, pw_2} = v.pw;
        rs1       = v.a;
        rs2       = v.b;
        carryless = v.cl;
        lhs_sign  = v.ls;
        rhs_sign  = v.rs;
    endtask

    // Scoreboard: every ready pulse must match the oldest outstanding accepted operation.
    always @(negedge g_clk) begin : monitor
        exp_t e;
        if (g_resetn && ready) begin
            if (sb_q.size() == 0) begin
                check("spurious_ready", 64'(ready), 64'd0);
            end else begin
                e = sb_q.pop_front();
                check({e.name, "_hi"}, 64'(result_hi), 64'(e.hi));
                check({e.name, "_lo"}, 64'(result_lo), 64'(e.lo));
            end
        end
    end

    // Runs one operation; with noise set, valid is re-asserted with junk operands in RUN cycles 5..10.
    task automatic do_op(input vec_t v, input bit noise);
        int el;
        int cyc;
        int bcnt;
        @(negedge g_clk);
        apply(v);
        valid = 1'b1;
        @(posedge g_clk);
        sb_q.push_back('{v.name, v.hi, v.lo});
        el = exp_lat(v.b, v.cl, v.rs);
        @(negedge g_clk);
        valid = 1'b0;
        rs1 = $urandom;
        rs2 = $urandom;
        carryless = 1'($urandom);
        cyc  = 1;
        bcnt = 0;
        while (!ready && cyc < 200) begin
            if (busy) bcnt++;
            @(negedge g_clk);
            cyc++;
            valid = noise && (cyc >= 5) && (cyc <= 10);
        end
        valid = 1'b0;
        check({v.name, "_latency"}, 64'(cyc), 64'(el));
        check({v.name, "_busy_cycles"}, 64'(bcnt), 64'(el - 1));
        @(negedge g_clk);
        check({v.name, "_ready_pulse"}, 64'(ready), 64'd0);
    endtask

    initial begin
        int   cyc;
        int   rcnt;
        vec_t v;

        tv.push_back(mk("u32_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'b10000, 0, 0, 0, 32'hFFFF_FFFE, 32'h0000_0001));
        tv.push_back(mk("s32_m1m1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'b10000, 0, 1, 1, 32'h0000_0000, 32'h0000_0001));
        tv.push_back(mk("su32_m1",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'b10000, 0, 1, 0, 32'hFFFF_FFFF, 32'h0000_0001));
        tv.push_back(mk("u8_a",     32'h0203_0405, 32'h1010_1010, 5'b00100, 0, 0, 0, 32'h0000_0000, 32'h2030_4050));
        tv.push_back(mk("u8_b",     32'hFF00_0000, 32'h0200_0000, 5'b00100, 0, 0, 0, 32'h0100_0000, 32'hFE00_0000));
        tv.push_back(mk("cl_3",     32'h0000_0003, 32'h0000_0003, 5'b10000, 1, 0, 0, 32'h0000_0000, 32'h0000_0005));
        tv.push_back(mk("cl_msb",   32'h8000_0000, 32'h8000_0000, 5'b10000, 1, 1, 1, 32'h4000_0000, 32'h0000_0000));
        tv.push_back(mk("no_pw",    32'h0001_0000, 32'h0001_0000, 5'b00000, 0, 0, 0, 32'h0000_0001, 32'h0000_0000));
        tv.push_back(mk("s16",      32'hFFFF_0002, 32'h0003_0003, 5'b01000, 0, 1, 1, 32'hFFFF_0000, 32'hFFFD_0006));
        tv.push_back(mk("s2",       32'hFFFF_FFFF, 32'hAAAA_AAAA, 5'b00001, 0, 1, 1, 32'h0000_0000, 32'hAAAA_AAAA));
        tv.push_back(mk("zero",     32'h1234_5678, 32'h0000_0000, 5'b10000, 0, 0, 0, 32'h0000_0000, 32'h0000_0000));
        for (int i = 0; i < 20; i++) begin
            logic [63:0] r;
            v = mk($sformatf("rnd%0d", i), $urandom, $urandom, 5'(1 << (i % 5)),
                   1'($urandom), 1'($urandom), 1'($urandom), '0, '0);
            r = model(v.a, v.b, v.pw, v.cl, v.ls, v.rs);
            v.hi = r[63:32];
            v.lo = r[31:0];
            tv.push_back(v);
        end

        repeat (3) @(negedge g_clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_ready", 64'(ready), 64'd0);
        check("reset_hi", 64'(result_hi), 64'd0);
        check("reset_lo", 64'(result_lo), 64'd0);
        g_resetn = 1'b1;

        for (int i = 0; i < tv.size(); i++)
            do_op(tv[i], 1'b0);

        // valid pulsed mid-RUN must be ignored
        do_op(tv[3], 1'b1);

        // flush at RUN cycle 10 with a competing valid: no ready, results kept from u8_a
        @(negedge g_clk);
        apply(tv[0]);
        valid = 1'b1;
        @(posedge g_clk);
        @(negedge g_clk);
        valid = 1'b0;
        repeat (9) @(negedge g_clk);
        flush = 1'b1;
        valid = 1'b1;
        @(negedge g_clk);
        flush = 1'b0;
        valid = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_hi_kept", 64'(result_hi), 64'(tv[3].hi));
        check("flush_lo_kept", 64'(result_lo), 64'(tv[3].lo));

        // flush blocks a same-cycle valid in IDLE
        apply(tv[0]);
        valid = 1'b1;
        flush = 1'b1;
        @(negedge g_clk);
        valid = 1'b0;
        flush = 1'b0;
        check("flush_idle_busy", 64'(busy), 64'd0);
        rcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge g_clk);
            if (ready) rcnt++;
        end
        check("flush_no_ready", 64'(rcnt), 64'd0);

        // back-to-back: valid held through RUN, second op accepted in the DONE cycle
        @(negedge g_clk);
        apply(tv[0]);
        valid = 1'b1;
        @(posedge g_clk);
        sb_q.push_back('{tv[0].name, tv[0].hi, tv[0].lo});
        @(negedge g_clk);
        apply(tv[5]);
        cyc = 1;
        while (!ready && cyc < 200) begin
            @(negedge g_clk);
            cyc++;
        end
        check("b2b_first_latency", 64'(cyc), 64'(exp_lat(tv[0].b, tv[0].cl, tv[0].rs)));
        @(posedge g_clk);
        sb_q.push_back('{tv[5].name, tv[5].hi, tv[5].lo});
        @(negedge g_clk);
        valid = 1'b0;
        check("b2b_second_busy", 64'(busy), 64'd1);
        cyc = 1;
        while (!ready && cyc < 200) begin
            @(negedge g_clk);
            cyc++;
        end
        check("b2b_second_latency", 64'(cyc), 64'(exp_lat(tv[5].b, tv[5].cl, tv[5].rs)));

        // async reset mid-RUN clears outputs immediately (last result was cl_3 = 5)
        @(negedge g_clk);
        apply(tv[0]);
        valid = 1'b1;
        @(posedge g_clk);
        @(negedge g_clk);
        valid = 1'b0;
        repeat (10) @(negedge g_clk);
        #2 g_resetn = 1'b0;
        #1;
        check("areset_busy", 64'(busy), 64'd0);
        check("areset_ready", 64'(ready), 64'd0);
        check("areset_hi", 64'(result_hi), 64'd0);
        check("areset_lo", 64'(result_lo), 64'd0);
        @(negedge g_clk);
        g_resetn = 1'b1;
        do_op(tv[1], 1'b0);

        repeat (3) @(negedge g_clk);
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
